// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, launches mult/div ops and holds busy for a
// fixed latency before committing the shadowed result.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [3:0]  MDUop,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdResult
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     hi_s_q, hi_s_d, lo_s_q, lo_s_d;
  logic            dz_q, dz_d;

  logic signed [63:0] sa64, sb64;
  logic [63:0]        prod_s, prod_u;
  logic [31:0]        q_s, r_s, q_u, r_u;
  logic               is_mult;

  always_comb begin
    sa64   = {{32{srcA[31]}}, srcA};
    sb64   = {{32{srcB[31]}}, srcB};
    prod_s = sa64 * sb64;
    prod_u = {32'h0, srcA} * {32'h0, srcB};
    q_s    = '0;
    r_s    = '0;
    q_u    = '0;
    r_u    = '0;
    if (srcB != 32'h0) begin
      q_u = srcA / srcB;
      r_u = srcA % srcB;
      // The only signed quotient that does not fit in 32 bits wraps to the dividend.
      if (srcA == 32'h8000_0000 && srcB == 32'hFFFF_FFFF) begin
        q_s = 32'h8000_0000;
        r_s = 32'h0;
      end else begin
        q_s = $signed(srcA) / $signed(srcB);
        r_s = $signed(srcA) % $signed(srcB);
      end
    end
  end

  assign is_mult = (MDUop == OpMult) || (MDUop == OpMultu);
  assign start   = (state_q == IDLE) && (MDUop >= OpMult) && (MDUop <= OpDivu);
  assign busy    = (state_q == BUSY);
  assign HI      = hi_q;
  assign LO      = lo_q;

  always_comb begin
    mdResult = 32'h0;
    if (MDUop == OpMfhi) mdResult = hi_q;
    else if (MDUop == OpMflo) mdResult = lo_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_s_d  = hi_s_q;
    lo_s_d  = lo_s_q;
    dz_d    = dz_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = BUSY;
        cnt_d   = is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        dz_d    = !is_mult && (srcB == 32'h0);
        case (MDUop)
          OpMult:  {hi_s_d, lo_s_d} = prod_s;
          OpMultu: {hi_s_d, lo_s_d} = prod_u;
          OpDiv:   {hi_s_d, lo_s_d} = {r_s, q_s};
          default: {hi_s_d, lo_s_d} = {r_u, q_u};
        endcase
      end else if (MDUop == OpMthi) begin
        hi_d = srcA;
      end else if (MDUop == OpMtlo) begin
        lo_d = srcA;
      end
    end else begin
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        state_d = IDLE;
        if (!dz_q) begin
          hi_d = hi_s_q;
          lo_d = lo_s_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_s_q  <= '0;
      lo_s_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_s_q  <= hi_s_d;
      lo_s_q  <= lo_s_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: a cycle-level reference model predicts each commit, a monitor
// checks HI/LO and busy length whenever busy falls.
module tb_e_mdu;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] srcA, srcB;
  logic [3:0]  MDUop;
  logic        start, busy;
  logic [31:0] HI, LO, mdResult;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk      (clk),
    .reset    (reset),
    .srcA     (srcA),
    .srcB     (srcB),
    .MDUop    (MDUop),
    .start    (start),
    .busy     (busy),
    .HI       (HI),
    .LO       (LO),
    .mdResult (mdResult)
  );

  typedef struct {
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   busy_cnt = 0;

  // Reference model state
  logic [31:0] hi_m, lo_m, pend_hi, pend_lo;
  int          left_m, n_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: whenever a busy period ends, pop the predicted commit and compare.
  always @(negedge clk) begin
    exp_t e;
    if (busy === 1'b1) begin
      busy_cnt++;
      if (busy_cnt == 64) begin
        total++;
        bad++;
        $display("FAIL busy_timeout: busy still high after %0d cycles", busy_cnt);
      end
    end else if (busy_cnt > 0) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_busy: got busy period of %0d cycles want none", busy_cnt);
      end else begin
        e = sb_q.pop_front();
        chk("busy_len", 32'(busy_cnt), 32'(e.len));
        chk("commit_HI", HI, e.hi);
        chk("commit_LO", LO, e.lo);
      end
      busy_cnt = 0;
    end
  end

  task automatic model_edge(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0]        p;
    exp_t               e;
    if (left_m > 0) begin
      left_m--;
      if (left_m == 0) begin
        hi_m = pend_hi;
        lo_m = pend_lo;
      end
    end else if (op >= 1 && op <= 4) begin
      sa      = $signed(a);
      sb      = $signed(b);
      pend_hi = hi_m;
      pend_lo = lo_m;
      case (op)
        4'd1: begin p = sa * sb; pend_hi = p[63:32]; pend_lo = p[31:0]; end
        4'd2: begin p = {32'h0, a} * {32'h0, b}; pend_hi = p[63:32]; pend_lo = p[31:0]; end
        4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; pend_lo = q[31:0]; pend_hi = r[31:0]; end
        default: if (b != 0) begin pend_lo = a / b; pend_hi = a % b; end
      endcase
      n_m    = (op <= 2) ? MC : DC;
      left_m = n_m;
      e.len = n_m;
      e.hi  = pend_hi;
      e.lo  = pend_lo;
      sb_q.push_back(e);
    end else if (op == 7) begin
      hi_m = a;
    end else if (op == 8) begin
      lo_m = a;
    end
  endtask

  // Called at posedge+1; drives one cycle of stimulus and advances the model across the edge.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] md_e;
    MDUop = op;
    srcA  = a;
    srcB  = b;
    #3;
    chk("start", {31'b0, start}, {31'b0, (left_m == 0 && op >= 1 && op <= 4)});
    md_e = (op == 5) ? hi_m : (op == 6) ? lo_m : 32'h0;
    chk("mdResult", mdResult, md_e);
    chk("HI", HI, hi_m);
    chk("LO", LO, lo_m);
    @(posedge clk);
    model_edge(op, a, b);
    #1;
  endtask

  task automatic drain();
    while (left_m > 0) step(4'd0, 32'h0, 32'h0);
    step(4'd0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_HI", HI, 32'h0);
    chk("rst_LO", LO, 32'h0);
    // An aborted operation shows up as a short busy period with no commit.
    if (left_m > 0) begin
      e = sb_q[$];
      sb_q.pop_back();
      e.len = n_m - left_m;
      e.hi  = 32'h0;
      e.lo  = 32'h0;
      sb_q.push_back(e);
    end
    left_m = 0;
    hi_m   = 32'h0;
    lo_m   = 32'h0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return $urandom_range(0, 15);
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'(-$urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset  = 1'b1;
    MDUop  = 4'd0;
    srcA   = 32'h0;
    srcB   = 32'h0;
    hi_m   = 32'h0;
    lo_m   = 32'h0;
    left_m = 0;
    n_m    = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", {31'b0, busy}, 32'h0);
    chk("init_HI", HI, 32'h0);
    chk("init_LO", LO, 32'h0);
    reset = 1'b0;

    // Signed multiply
    step(4'd1, 32'hFFFF_FFFE, 32'd3);
    drain();
    chk("mult_HI", HI, 32'hFFFF_FFFF);
    chk("mult_LO", LO, 32'hFFFF_FFFA);
    step(4'd5, 32'h0, 32'h0);

    // Unsigned multiply and divide
    step(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain();
    chk("multu_HI", HI, 32'hFFFF_FFFE);
    chk("multu_LO", LO, 32'h0000_0001);
    step(4'd4, 32'd7, 32'd2);
    drain();
    chk("divu_HI", HI, 32'd1);
    chk("divu_LO", LO, 32'd3);

    // Signed divide, overflow, divide by zero
    step(4'd3, 32'hFFFF_FFF9, 32'd2);
    drain();
    chk("div_HI", HI, 32'hFFFF_FFFF);
    chk("div_LO", LO, 32'hFFFF_FFFD);
    step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    drain();
    chk("ovf_HI", HI, 32'h0);
    chk("ovf_LO", LO, 32'h8000_0000);
    step(4'd7, 32'h11, 32'h0);
    step(4'd8, 32'h22, 32'h0);
    step(4'd3, 32'd5, 32'h0);
    drain();
    chk("dz_HI", HI, 32'h11);
    chk("dz_LO", LO, 32'h22);

    // Ops while busy are ignored
    step(4'd1, 32'd2, 32'd3);
    step(4'd1, 32'd5, 32'd5);
    step(4'd8, 32'hAA, 32'h0);
    drain();
    chk("busy_ign_HI", HI, 32'h0);
    chk("busy_ign_LO", LO, 32'd6);
    step(4'd8, 32'hAA, 32'h0);
    step(4'd0, 32'h0, 32'h0);
    chk("mtlo_LO", LO, 32'hAA);

    // Reset in the fourth busy cycle of a divide
    step(4'd3, 32'd100, 32'd7);
    repeat (3) step(4'd0, 32'h0, 32'h0);
    do_reset();
    repeat (15) step(4'd0, 32'h0, 32'h0);
    step(4'd2, 32'd9, 32'd9);
    drain();

    // Randomized traffic, including ops issued while busy
    repeat (400) step(4'($urandom_range(0, 15)), rand_operand(), rand_operand());
    drain();

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
